// File: rtl/ro_sched_n.sv
// ---------------------------------------------------------------------------
// ro_sched_n : gray-clock readout scheduler for the cochlea core array.
//
// A binary counter advances once per enabled clk_master cycle. The gray bit
// that toggles on each increment names the core that owns the shared readout
// bus for one cycle, so core i is served every 2^(i+1) cycles.
//
// Ports
//   clk_master  master clock, all state updates on posedge
//   rstb        asynchronous active-low reset
//   en          counter / scheduler enable
//   core_en     per-core slot enable mask (NCORE bits)
//   in_data     core outputs, core i at [i*NCH +: NCH]
//   gray        current gray count (cnt ^ cnt>>1)
//   ro_oe       registered bus drive enable
//   ro_core     index of the core currently driving the bus
//   ro_data     readout bus, high impedance while ro_oe is low
//   frame       one-cycle pulse following a counter wrap
// ---------------------------------------------------------------------------
module ro_sched_n #(
    parameter int NCORE = 6,
    parameter int NCH   = 2,
    parameter int CW    = 8,
    parameter int IDW   = 3
) (
    input  logic                  clk_master,
    input  logic                  rstb,
    input  logic                  en,
    input  logic [NCORE-1:0]      core_en,
    input  logic [NCORE*NCH-1:0]  in_data,
    output logic [CW-1:0]         gray,
    output logic                  ro_oe,
    output logic [IDW-1:0]        ro_core,
    output logic [NCH-1:0]        ro_data,
    output logic                  frame
);

    localparam int TW = $clog2(CW) + 1;

    logic [CW-1:0]  r_cnt;
    logic           r_oe;
    logic [IDW-1:0] r_core;
    logic [NCH-1:0] r_data;
    logic           r_frame;

    logic [TW-1:0]  w_t;
    logic           w_found;
    logic           w_grant;
    logic [IDW-1:0] w_idx;
    logic [NCH-1:0] w_sel;

    // Trailing-ones count of the current count = the gray bit that toggles
    // on this increment. An all-ones count (the wrap) toggles the top bit.
    always_comb begin
        w_t     = TW'(CW - 1);
        w_found = 1'b0;
        for (int i = 0; i < CW; i++) begin
            if (!w_found && !r_cnt[i]) begin
                w_t     = TW'(i);
                w_found = 1'b1;
            end
        end
    end

    // Decode the toggling bit into a grant. Bits at or above NCORE never
    // match, which makes those slots idle.
    always_comb begin
        w_grant = 1'b0;
        w_idx   = '0;
        w_sel   = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (w_t == TW'(i) && core_en[i]) begin
                w_grant = 1'b1;
                w_idx   = IDW'(i);
                w_sel   = in_data[i*NCH +: NCH];
            end
        end
    end

    // Index and data registers hold through idle and masked slots; only the
    // drive enable drops, so the bus goes quiet without losing the last core.
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            r_cnt   <= '0;
            r_oe    <= 1'b0;
            r_core  <= '0;
            r_data  <= '0;
            r_frame <= 1'b0;
        end else if (en) begin
            r_cnt   <= r_cnt + CW'(1);
            r_frame <= &r_cnt;
            if (w_grant) begin
                r_oe   <= 1'b1;
                r_core <= w_idx;
                r_data <= w_sel;
            end else begin
                r_oe   <= 1'b0;
            end
        end else begin
            r_oe    <= 1'b0;
            r_frame <= 1'b0;
        end
    end

    assign gray    = r_cnt ^ (r_cnt >> 1);
    assign ro_oe   = r_oe;
    assign ro_core = r_core;
    assign ro_data = r_oe ? r_data : {NCH{1'bz}};
    assign frame   = r_frame;

endmodule

// File: tb/tb_ro_sched_n.sv
// ---------------------------------------------------------------------------
// tb_ro_sched_n : directed self-checking bench for ro_sched_n, configured
// with NCORE=4, NCH=2, CW=5, IDW=2. Inputs change and outputs are sampled
// on the falling edge of clk_master.
// ---------------------------------------------------------------------------
module tb_ro_sched_n;

    logic       clk_master = 1'b0;
    logic       rstb       = 1'b0;
    logic       en         = 1'b0;
    logic [3:0] core_en    = 4'h0;
    logic [7:0] in_data    = 8'h00;
    wire  [4:0] gray;
    wire        ro_oe;
    wire  [1:0] ro_core;
    wire  [1:0] ro_data;
    wire        frame;

    int testCount = 0;
    int failCount = 0;

    // Core owning the slot for count c = 0..15 (4 = idle slot at c=15).
    int expCore [16] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 2, 0, 1, 0, 4};

    ro_sched_n #(
        .NCORE(4),
        .NCH  (2),
        .CW   (5),
        .IDW  (2)
    ) dut (
        .clk_master(clk_master),
        .rstb      (rstb),
        .en        (en),
        .core_en   (core_en),
        .in_data   (in_data),
        .gray      (gray),
        .ro_oe     (ro_oe),
        .ro_core   (ro_core),
        .ro_data   (ro_data),
        .frame     (frame)
    );

    always #5 clk_master = ~clk_master;

    task automatic applyStimulus(input logic rb, input logic e,
                                 input logic [3:0] ce, input logic [7:0] d);
        rstb    = rb;
        en      = e;
        core_en = ce;
        in_data = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // The bus is released when it reads z (or the 2-state stand-in 00);
    // a leaked register value shows up as anything else.
    function automatic logic busReleased();
        return (ro_data === 2'bzz) || (ro_data === 2'b00);
    endfunction

    initial begin
        // Reset state
        @(negedge clk_master);
        @(negedge clk_master);
        checkOutput("rst oe",    ro_oe,   1'b0);
        checkOutput("rst core",  ro_core, 2'd0);
        checkOutput("rst gray",  gray,    5'd0);
        checkOutput("rst frame", frame,   1'b0);
        checkOutput("rst bus",   busReleased(), 1'b1);

        // Full schedule through the wrap, core i presents i
        applyStimulus(1'b1, 1'b1, 4'hF, 8'b11_10_01_00);
        for (int k = 0; k <= 32; k++) begin
            int c;
            c = expCore[k % 16];
            @(negedge clk_master);
            checkOutput($sformatf("sched oe c=%0d", k), ro_oe, (c != 4));
            if (c != 4) begin
                checkOutput($sformatf("sched core c=%0d", k), ro_core, c[1:0]);
                checkOutput($sformatf("sched data c=%0d", k), ro_data, c[1:0]);
            end else begin
                checkOutput($sformatf("sched bus c=%0d", k), busReleased(), 1'b1);
            end
            checkOutput($sformatf("frame c=%0d", k), frame, (k == 31));
            if (k == 30) checkOutput("gray pre-wrap", gray, 5'b10000);
            if (k == 31) checkOutput("gray wrap",     gray, 5'b00000);
        end

        // Core 1 masked, core i presents ~i
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h00);
        @(negedge clk_master);
        applyStimulus(1'b1, 1'b1, 4'b1101, 8'b00_01_10_11);
        for (int k = 0; k < 16; k++) begin
            int c;
            logic [1:0] d;
            c = expCore[k];
            d = ~c[1:0];
            @(negedge clk_master);
            checkOutput($sformatf("mask oe c=%0d", k), ro_oe, (c != 4 && c != 1));
            if (c != 4 && c != 1) begin
                checkOutput($sformatf("mask core c=%0d", k), ro_core, c[1:0]);
                checkOutput($sformatf("mask data c=%0d", k), ro_data, d);
            end else begin
                checkOutput($sformatf("mask bus c=%0d", k), busReleased(), 1'b1);
            end
        end

        // Enable held low for three cycles at c=6
        applyStimulus(1'b0, 1'b0, 4'hF, 8'h00);
        @(negedge clk_master);
        applyStimulus(1'b1, 1'b1, 4'hF, 8'b11_10_01_00);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_master);
        end
        checkOutput("pre-hold core", ro_core, 2'd1);
        applyStimulus(1'b1, 1'b0, 4'hF, 8'b11_10_01_00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_master);
            checkOutput($sformatf("hold oe %0d", k),   ro_oe, 1'b0);
            checkOutput($sformatf("hold gray %0d", k), gray,  5'b00101);
            checkOutput($sformatf("hold bus %0d", k),  busReleased(), 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 4'hF, 8'b11_10_01_00);
        @(negedge clk_master);
        checkOutput("resume c6 oe",   ro_oe,   1'b1);
        checkOutput("resume c6 core", ro_core, 2'd0);
        @(negedge clk_master);
        checkOutput("resume c7 oe",   ro_oe,   1'b1);
        checkOutput("resume c7 core", ro_core, 2'd3);
        checkOutput("resume c7 data", ro_data, 2'd3);

        // Asynchronous reset while the bus is driven
        #2 rstb = 1'b0;
        #1;
        checkOutput("async oe",   ro_oe,   1'b0);
        checkOutput("async gray", gray,    5'd0);
        checkOutput("async core", ro_core, 2'd0);
        checkOutput("async bus",  busReleased(), 1'b1);
        @(negedge clk_master);
        applyStimulus(1'b1, 1'b1, 4'hF, 8'b11_10_01_00);
        @(negedge clk_master);
        checkOutput("post-rst oe",   ro_oe,   1'b1);
        checkOutput("post-rst core", ro_core, 2'd0);
        checkOutput("post-rst gray", gray,    5'b00001);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
